// File: rtl/scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// scan_decoder_pkg
//   Shared types and constants for the scan_decoder block.
//   - state_t     : controller state (IDLE, DIRECT, SCAN)
//   - MODE_DIRECT : mode input value selecting decode of the accepted select
//   - MODE_SCAN   : mode input value selecting the autonomous output walk
// -----------------------------------------------------------------------------
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// -----------------------------------------------------------------------------
// scan_decoder_if
//   Select-transfer port of the scan_decoder.
//   Handshake: a transfer happens on every rising clk edge where sel_valid and
//   sel_ready are both high; sel is sampled on that edge. The master holds
//   sel stable while sel_valid is high and may assert sel_valid on any cycle;
//   sel_ready is combinational and may drop without a transfer.
//   Signals:
//     sel_valid  master -> slave  select transfer valid
//     sel        master -> slave  select value (SEL_W bits)
//     sel_ready  slave  -> master select transfer ready
// -----------------------------------------------------------------------------
interface scan_decoder_if #(
    parameter int SEL_W = 2
) ();

    logic             sel_valid;
    logic             sel_ready;
    logic [SEL_W-1:0] sel;

    modport master (
        output sel_valid,
        output sel,
        input  sel_ready
    );

    modport slave (
        input  sel_valid,
        input  sel,
        output sel_ready
    );

endinterface

// File: rtl/scan_decoder_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
//   Free-running dwell counter for the scan walk. Counts up every cycle and
//   reloads to 0 when it reaches limit; step pulses for the cycle in which
//   count equals limit. limit is compared live, so a new value takes effect
//   at the next compare.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     clear  in   synchronous clear; forces count to 0 and suppresses step
//     limit  in   DWELL_W-bit compare value
//     step   out  one-cycle pulse when count == limit (and not clear)
// -----------------------------------------------------------------------------
module dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [DWELL_W-1:0] limit,
    output logic               step
);

    logic [DWELL_W-1:0] count;
    logic               hit;

    assign hit  = (count == limit);
    assign step = hit & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || hit) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered N-to-2^N one-hot decoder with enable, a valid/ready select port
//   and an autonomous scan mode that walks the outputs with a programmable
//   dwell time (each line held dwell+1 cycles).
//   Parameters:
//     SEL_W    select width; dout has 2**SEL_W lines
//     DWELL_W  width of the dwell field
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     en      in   block enable; 0 forces outputs idle
//     mode    in   MODE_DIRECT (decode accepted select) / MODE_SCAN (auto-walk)
//     dwell   in   scan hold; each output held dwell+1 cycles
//     sel_if  slave modport: sel_valid, sel, sel_ready
//     dout    out  registered one-hot output (all-zero when idle)
//     idx     out  registered index of the active dout line
//     wrap    out  registered one-cycle pulse on scan wrap-around
//     state   out  current controller state (debug)
//   Build option:
//     SCAN_DECODER_ACTLOW_EN  when defined, dout is active-low: idle/reset is
//                             all ones and the selected line is 0.
// -----------------------------------------------------------------------------
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [DWELL_W-1:0]    dwell,
    scan_decoder_if.slave         sel_if,
    output logic [2**SEL_W-1:0]   dout,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output state_t                state
);

    localparam int               N       = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] idx_inc;
    logic [N-1:0]     hot_q;
    logic [N-1:0]     hot_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             take;
    logic             scan_run;
    logic             step;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Ready includes rst_n so that nothing looks acceptable while in reset.
    assign sel_if.sel_ready = en & (mode == MODE_DIRECT) & rst_n;
    assign take             = sel_if.sel_valid & sel_if.sel_ready;

    // The counter only runs while we stay in SCAN; any entry edge clears it so
    // the first line gets its full dwell+1 cycles.
    assign scan_run = (state_q == SCAN) && (state_d == SCAN);
    assign idx_inc  = idx_q + 1'b1;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~scan_run),
        .limit (dwell),
        .step  (step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = IDLE;
        idx_d   = idx_q;
        hot_d   = hot_q;
        wrap_d  = 1'b0;

        // en has priority over mode.
        if (!en) begin
            state_d = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_d = SCAN;
        end else begin
            state_d = DIRECT;
        end

        case (state_d)
            IDLE: begin
                idx_d = '0;
                hot_d = '0;
            end
            DIRECT: begin
                // Without a transfer the last value (scan or direct) holds.
                if (take) begin
                    idx_d = sel_if.sel;
                    hot_d = onehot(sel_if.sel);
                end
            end
            SCAN: begin
                if (!scan_run) begin
                    idx_d = '0;
                    hot_d = onehot('0);
                end else if (step) begin
                    idx_d  = idx_inc;
                    hot_d  = onehot(idx_inc);
                    wrap_d = (idx_q == IDX_MAX);
                end
            end
            default: begin
                idx_d = '0;
                hot_d = '0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            hot_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            hot_q  <= hot_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef SCAN_DECODER_ACTLOW_EN
    assign dout = ~hot_q;
`else
    assign dout = hot_q;
`endif

    assign idx   = idx_q;
    assign wrap  = wrap_q;
    assign state = state_q;

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with enable, a valid/ready select port and an autonomous scan mode. It is the next generation of the team's 2-to-4 enable decoder. It drives one-hot strobes such as row selects, mux selects and LED/segment digit scanning. In scan mode it walks the outputs itself with a programmable dwell time, so the upstream logic does not have to sequence the select input.

## Interface
Parameters:
- SEL_W, default 2: select width; the output has 2**SEL_W lines.
- DWELL_W, default 4: width of the dwell field.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable. 0 forces outputs idle.
- mode  in  1  0 = DIRECT (decode the accepted select), 1 = SCAN (auto-walk).
- sel_valid  in  1  select transfer valid (DIRECT only).
- sel_ready  out  1  select transfer ready. Combinational: en & ~mode & rst_n.
- sel  in  SEL_W  select value.
- dwell  in  DWELL_W  scan hold. Each output is held dwell+1 cycles.
- dout  out  2**SEL_W  registered one-hot output.
- idx  out  SEL_W  registered index of the active dout bit.
- wrap  out  1  registered one-cycle pulse on scan wrap-around.

## Operation
- States: IDLE, DIRECT, SCAN.
- IDLE is entered at reset or whenever en=0.
  - In IDLE, dout=0, idx=0, wrap=0, and the dwell counter is 0.
- When en=1, the next state is DIRECT if mode=0 and SCAN if mode=1.
- DIRECT behaviour:
  - A transfer occurs on a cycle where sel_valid & sel_ready.
  - On the following edge, dout = 1<<sel and idx = sel.
  - dout holds until the next transfer.
  - If no transfer has occurred since IDLE, dout=0.
- SCAN behaviour:
  - On entry from IDLE or DIRECT, idx=0, dout=1 and the dwell counter is 0.
  - The counter increments each cycle.
  - When the counter equals the live dwell input, the counter resets and idx advances by 1.
  - From idx = 2**SEL_W-1, idx wraps to 0. wrap=1 on the same edge that dout returns to bit 0, and only for that cycle.
  - dwell=0 advances idx every cycle.
  - dwell may change mid-scan. The new value takes effect at the next compare.
- Mode changes:
  - SCAN to DIRECT: dout/idx keep their last scan value until a transfer is accepted.
  - DIRECT to SCAN: the scan restarts at idx 0.
- dout is always one-hot or all-zero and is never multi-hot.

## Timing
- Reset values: dout=0, idx=0, wrap=0, state IDLE. sel_ready=0 while rst_n=0.
- Reset asserted mid-scan clears all state immediately (asynchronously). The first active edge after release behaves as IDLE followed by entry.
- DIRECT latency: 1 cycle from the accepting edge to dout.
- Back-to-back transfers are accepted every cycle.
- SCAN latency: dout=1 on the first edge with mode=1 & en=1.
  - Step period is dwell+1 cycles.
  - Full sweep is 2**SEL_W*(dwell+1) cycles.
- en falling:
  - dout=0 on the next edge.
  - sel_ready drops in the same cycle, so a coincident sel_valid is not accepted.
- en and mode changing in the same cycle: en takes priority. The next state is IDLE.
- wrap never asserts in DIRECT or IDLE.

## Configuration
- SCAN_DECODER_ACTLOW_EN:
  - When defined, dout is active-low.
  - The idle/reset value is all ones, and the selected line is 0, i.e. ~(1<<idx).
  - idx, wrap and sel_ready are unchanged.
- When undefined, dout is active-high as described above.

## Structure
- Package scan_decoder_pkg holds:
  - the state enum typedef (IDLE, DIRECT, SCAN);
  - the mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
- One sub-module, dwell_counter (DWELL_W-bit):
  - inputs: clk, rst_n, clear, limit;
  - output: a one-cycle step pulse when count==limit.
- The top level holds the FSM, the idx register, the one-hot decode and the polarity option.

## Test plan
All scenarios use SEL_W=2 and DWELL_W=4.
- Reset, then en=1, mode=0, sel=2 with sel_valid for one cycle: dout=4'b0100 and idx=2 one cycle later; the value holds for 10 cycles with no further transfer.
- DIRECT back-to-back, sel=0,1,2,3 on consecutive cycles: dout reads 0001, 0010, 0100, 1000 on consecutive cycles with no gaps.
- mode=1, dwell=2: each dout bit is held 3 cycles, the sweep repeats every 12 cycles, and wrap pulses exactly once per sweep, coincident with dout=0001.
- SCAN with dwell=0: dout rotates every cycle, and wrap fires every 4 cycles.
- en=0 asserted during scan and during DIRECT with coincident sel_valid: dout=0 next edge, no transfer accepted, wrap=0.
- rst_n pulsed low mid-scan at idx=2: outputs clear asynchronously (dout=0); after release with mode=1, the scan restarts at dout=0001.
- With SCAN_DECODER_ACTLOW_EN defined: rerun scenarios 1 and 3 with every dout value inverted; reset value is 4'b1111.
